// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder with control-token alignment.
// Slips the 10-bit window until LOCK_COUNT consecutive tokens are seen.
module tmds_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_LAST   = RW'(LOCK_COUNT - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t        state;
    logic [9:0]    prev_sym;
    logic [3:0]    offset;
    logic [RW-1:0] run;
    logic [TW-1:0] timer;

    logic [19:0] w;
    logic [9:0]  win;
    logic        is_ctrl;
    logic [1:0]  ctrl;
    logic [7:0]  t;
    logic [7:0]  dx;
    logic [7:0]  d;
    logic [3:0]  next_offset;

    // The window may straddle the previous and current words.
    assign w   = {tmds_in, prev_sym};
    assign win = 10'(w >> offset);

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (win)
            10'b1101010100: ctrl = 2'b00;
            10'b0010101011: ctrl = 2'b01;
            10'b0101010100: ctrl = 2'b10;
            10'b1010101011: ctrl = 2'b11;
            default:        is_ctrl = 1'b0;
        endcase
    end

    assign t  = win[9] ? ~win[7:0] : win[7:0];
    assign dx = t ^ {t[6:0], 1'b0};
    assign d  = {win[8] ? dx[7:1] : ~dx[7:1], t[0]};

    assign next_offset = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= SEARCH;
            prev_sym    <= '0;
            offset      <= '0;
            run         <= '0;
            timer       <= '0;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
        end else begin
            prev_sym    <= tmds_in;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
            unique case (state)
                SEARCH: begin
                    if (is_ctrl && run == RUN_LAST) begin
                        state <= LOCKED;
                        run   <= '0;
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        offset <= next_offset;
                        run    <= '0;
                        timer  <= '0;
                    end else begin
                        run   <= is_ctrl ? run + RW'(1) : '0;
                        timer <= timer + TW'(1);
                    end
                end
                LOCKED: begin
                    if (is_ctrl) begin
                        timer       <= '0;
                        control_out <= ctrl;
                    end else begin
                        ve_out   <= 1'b1;
                        data_out <= d;
                        if (timer == TIMER_LAST) begin
                            state  <= SEARCH;
                            offset <= next_offset;
                            run    <= '0;
                            timer  <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign locked_out = (state == LOCKED);
    assign offset_out = offset;
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: scoreboard bench for tmds_decoder.
// Covers lock, data round trip, misalignment, lock loss, offset wrap, reset.
module tb_tmds_decoder;
    localparam int LOCK_COUNT = 8;
    localparam int TIMEOUT    = 32;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] tmds = '0;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       locked_out;
    logic [3:0] offset_out;

    typedef struct packed {
        logic        chk;
        logic [10:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    tmds_decoder #(
        .LOCK_COUNT(LOCK_COUNT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .tmds_in    (tmds),
        .data_out   (data_out),
        .control_out(control_out),
        .ve_out     (ve_out),
        .locked_out (locked_out),
        .offset_out (offset_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference DVI encoder; pol selects the q_out[9] inversion.
    function automatic logic [9:0] enc(input logic [7:0] b, input logic pol);
        logic [8:0] qm;
        int ones;
        ones  = $countones(b);
        qm[0] = b[0];
        if (ones > 4 || (ones == 4 && !b[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        return pol ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] s, input int k);
        logic [19:0] dd;
        dd = {s, s} << k;
        return dd[19:10];
    endfunction

    task automatic step(input logic [9:0] word, input logic chk,
                        input logic [10:0] exp);
        sb_t e;
        tmds    = word;
        e.chk   = chk;
        e.exp   = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            if (e.chk) check("sb_out", {ve_out, control_out, data_out}, e.exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        sb_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_to_offset(input logic [9:0] word, input logic [3:0] target,
                                 output int n);
        n = 0;
        while (offset_out !== target && n < 400) begin
            step(word, 1'b0, '0);
            n++;
        end
    endtask

    initial begin
        logic [7:0] bytes[5];
        logic [7:0] b;
        int n;
        bytes = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h10};

        do_reset(2);
        check("rst_out", {ve_out, control_out, data_out}, 32'd0);
        check("rst_lock", locked_out, 32'd0);
        check("rst_off", offset_out, 32'd0);

        // Aligned lock on the 00 token
        for (int i = 1; i <= 9; i++) begin
            step(TOK0, 1'b1, '0);
            if (i == 8) check("lock_early", locked_out, 32'd0);
        end
        check("lock_at9", locked_out, 32'd1);
        check("lock_off", offset_out, 32'd0);
        step(TOK0, 1'b1, '0);
        step(TOK0, 1'b1, '0);

        // Data round trip, both polarities
        foreach (bytes[i]) begin
            for (int p = 0; p < 2; p++)
                step(enc(bytes[i], p[0]), 1'b1, {3'b100, bytes[i]});
        end
        repeat (3) step(TOK0, 1'b1, '0);
        check("data_lock", locked_out, 32'd1);

        // 31 data words then a token keeps lock
        for (int i = 0; i < 31; i++) begin
            b = 8'(i * 37 + 3);
            step(enc(b, i[0]), 1'b1, {3'b100, b});
        end
        repeat (4) step(TOK0, 1'b1, '0);
        check("hold_lock", locked_out, 32'd1);
        check("hold_off", offset_out, 32'd0);

        // 32 data words drops lock
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 53 + 11);
            step(enc(b, i[1]), 1'b1, {3'b100, b});
        end
        check("pre_drop", locked_out, 32'd1);
        step(10'h000, 1'b1, '0);
        check("drop_lock", locked_out, 32'd0);
        check("drop_off", offset_out, 32'd1);
        repeat (3) step(10'h000, 1'b1, '0);

        // Lock at offset 5 on the 11 token, then reset
        run_to_offset(10'h000, 4'd5, n);
        check("reach5", offset_out, 32'd5);
        repeat (12) step(rotl(TOK3, 5), 1'b0, '0);
        check("lock5", locked_out, 32'd1);
        check("lock5_off", offset_out, 32'd5);
        check("lock5_ctrl", {ve_out, control_out, data_out}, {21'd0, 3'b011, 8'd0});
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("mrst_out", {ve_out, control_out, data_out}, 32'd0);
        check("mrst_off", offset_out, 32'd0);
        check("mrst_lock", locked_out, 32'd0);
        rst = 1'b0;

        // Misaligned 01 token, shifted by 3 bits
        for (int k = 1; k <= 3; k++) begin
            run_to_offset(rotl(TOK1, 3), 4'(k), n);
            check($sformatf("mis_step%0d", k), n, TIMEOUT);
        end
        n = 0;
        while (locked_out !== 1'b1 && n < 100) begin
            step(rotl(TOK1, 3), 1'b0, '0);
            n++;
        end
        check("mis_lock_t", n, LOCK_COUNT);
        check("mis_off", offset_out, 32'd3);
        step(rotl(TOK1, 3), 1'b0, '0);
        step(rotl(TOK1, 3), 1'b0, '0);
        check("mis_ctrl", {ve_out, control_out, data_out}, {21'd0, 3'b001, 8'd0});

        // Offset wrap with no tokens at all
        do_reset(1);
        for (int k = 1; k <= 10; k++) begin
            run_to_offset(10'h000, 4'(k % 10), n);
            check($sformatf("wrap%0d", k % 10), n, TIMEOUT);
            check("wrap_lock", locked_out, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side TMDS channel decoder for the HDMI/DVI path. It takes one raw, possibly bit-misaligned 10-bit TMDS word per pixel clock from the deserializer and finds the symbol boundary using the four control tokens. It then recovers the 8-bit video data, the 2-bit control value and the video-enable flag. One instance is used per colour channel; the blue channel's control output carries {vs, hs}.

## Interface
- LOCK_COUNT, default 8: consecutive control-token windows at one offset needed to declare lock.
- TIMEOUT, default 4096: cycles without success before a bit-slip in SEARCH, or before lock is dropped in LOCKED. Must exceed one video line. Counter width is $clog2(TIMEOUT+1).
- clk_in, input, 1: pixel clock. The block uses this single clock.
- rst_in, input, 1: synchronous, active-high reset.
- tmds_in, input, 10: raw parallel word. Bit 0 is the earliest serial bit.
- data_out, output, 8: decoded pixel byte. It is 0 when ve_out=0 or when unlocked.
- control_out, output, 2: decoded control value. It is 0 when ve_out=1 or when unlocked.
- ve_out, output, 1: 1 when the decoded window is a data symbol.
- locked_out, output, 1: 1 while in state LOCKED.
- offset_out, output, 4: current bit-slip offset, 0..9.

## Operation
- prev_sym register holds the previous tmds_in value. The 20-bit vector w = {tmds_in, prev_sym}, and the decode window is win = w[offset +: 10].
- Control tokens map as follows:
  - 1101010100 → 00
  - 0010101011 → 01
  - 0101010100 → 10
  - 1010101011 → 11
- is_ctrl is true when win equals any of the four tokens.
- Data decode:
  - If win[9]=1, t = ~win[7:0]; otherwise t = win[7:0].
  - d[0] = t[0].
  - For i = 1..7: if win[8]=1, d[i] = t[i]^t[i-1]; otherwise d[i] = ~(t[i]^t[i-1]).
  - No disparity check is performed. The decoder is stateless apart from alignment.
- State machine has two states, SEARCH and LOCKED. State, offset, run counter and timer reset to SEARCH, 0, 0, 0.
- SEARCH:
  - run is incremented when is_ctrl, and cleared to 0 otherwise.
  - timer is incremented every cycle.
  - When is_ctrl and run==LOCK_COUNT-1: go to LOCKED and clear run and timer. This has priority over the timeout.
  - Otherwise, when timer==TIMEOUT-1: offset is incremented, wrapping 9→0, and run and timer are cleared.
- LOCKED:
  - timer is cleared on is_ctrl, and incremented otherwise.
  - When !is_ctrl and timer==TIMEOUT-1: go to SEARCH, increment offset (wrapping 9→0), and clear run and timer.
  - Offset is otherwise held.
- Output register, loaded every cycle:
  - If state (before the edge) is LOCKED and is_ctrl: ve_out=0, control_out=token value, data_out=0.
  - If state is LOCKED and !is_ctrl: ve_out=1, data_out=d, control_out=0.
  - If state is SEARCH: all outputs are 0.
- Reset mid-operation returns the block to SEARCH at offset 0 on the next edge, discarding lock.

## Timing
- Reset values: data_out=0, control_out=0, ve_out=0, locked_out=0, offset_out=0. prev_sym is also cleared to 0.
- Latency at offset 0: a word presented on tmds_in at edge N appears decoded on the outputs after edge N+2. At offset k>0 the window spans words N and N+1, with the same edge-N+2 output.
- locked_out rises at the edge that evaluates the LOCK_COUNT-th consecutive token. Decoded outputs become non-zero from the following edge, so locked_out leads decoded outputs by one cycle.
- An offset change takes effect for the window evaluated at the next edge. No pipeline flush is done; one stale window is acceptable because outputs are gated while in SEARCH.
- On loss of lock, locked_out and the outputs drop at the same edge in which the timeout fires, plus one edge for the output register.

## Test plan
- Reset, then tokens at offset 0 (LOCK_COUNT=8):
  - Feed 1101010100 repeatedly. locked_out rises after the 9th edge following the first word (1 edge for prev_sym, 8 for the run).
  - Then ve_out=0, control_out=00, and offset_out stays 0.
- Data round trip:
  - After lock, feed the reference-encoder outputs for bytes 0x00, 0xFF, 0x55, 0xA5 and 0x10, with both q_out[9] polarities.
  - Required: data_out equals each byte two edges later, with ve_out=1.
- Misaligned stream (TIMEOUT=32):
  - Shift the repeated 0010101011 token by 3 bits, so that prev[9:3]=S[6:0] and tmds_in[2:0]=S[9:7].
  - Required: offset_out steps 0→1→2→3 at 32-cycle intervals, lock is reached at offset 3, and control_out=01.
- Loss of lock (TIMEOUT=32):
  - While locked, feed 32 consecutive non-token words.
  - Required: locked_out falls, offset_out goes to (k+1) mod 10, and the outputs go to 0.
  - Feeding 31 non-token words followed by one token keeps the block locked.
- Offset wrap:
  - Use a stream with no tokens.
  - Required: offset_out cycles through 0..9 and wraps back to 0, and locked_out stays 0.
- Reset mid-lock:
  - Assert rst_in for 1 cycle while locked at offset 5.
  - Required: on the next edge all outputs are 0 and offset_out=0.
